// File: rtl/cpu_bus_arbiter_if.sv
// CPU-bus arbitration signal bundle between the DMA datapath/bus pins and cpu_bus_arbiter.
// The master side drives requests and sensed bus status; the slave side is the arbiter.
interface cpu_bus_arbiter_if;
   localparam int unsigned BCOUNT_W = 2;

   logic                dma_ena;
   logic                dreq;
   logic                flush;
   logic                bgrant_n;
   logic                bgack_in_n;
   logic                as_in_n;
   logic                cycle_done;
   logic                breq;
   logic                bgack;
   logic                start;
   logic                owned;
   logic [BCOUNT_W-1:0] bcount;
   logic                timeout;

   modport master (
      output dma_ena, dreq, flush, bgrant_n, bgack_in_n, as_in_n, cycle_done,
      input  breq, bgack, start, owned, bcount, timeout
   );

   modport slave (
      input  dma_ena, dreq, flush, bgrant_n, bgack_in_n, as_in_n, cycle_done,
      output breq, bgack, start, owned, bcount, timeout
   );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// 68030 bus-mastership arbiter for DMA: request, grant, up to 4-cycle bursts, release and holdoff.
// Optional grant watchdog built when CPU_ARB_WATCHDOG_EN is defined.
module cpu_bus_arbiter (
   input  logic               clk,
   input  logic               rst_n,
   cpu_bus_arbiter_if.slave   bus
);
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned HOLD_W = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAITBUS,
      S_OWN,
      S_RUN,
      S_REL,
      S_HOLDOFF
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   bcount_q;
   logic [CNT_W-1:0]   bcount_nxt;
   logic [HOLD_W-1:0]  hold_q;
   logic [HOLD_W-1:0]  hold_nxt;
   logic               breq_q;
   logic               bgack_q;
   logic               start_q;
   logic               owned_q;
   logic               breq_nxt;
   logic               bgack_nxt;
   logic               start_nxt;
   logic               wd_expire;
   logic               timeout_cur;

`ifdef CPU_ARB_WATCHDOG_EN
   localparam int unsigned WD_W = 8;

   logic [WD_W-1:0]    wd_q;
   logic [WD_W-1:0]    wd_nxt;
   logic               timeout_q;
   logic               timeout_nxt;

   assign wd_expire   = (wd_q == '1);
   assign timeout_cur = timeout_q;

   // Watchdog counts consecutive request/wait cycles; timeout sticks until DMA is disabled.
   always_comb begin
      wd_nxt      = '0;
      timeout_nxt = timeout_q;
      if (breq_nxt) begin
         wd_nxt = wd_q + WD_W'(1);
      end
      if (!bus.dma_ena) begin
         timeout_nxt = 1'b0;
      end else if (wd_expire) begin
         timeout_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_q      <= wd_nxt;
         timeout_q <= timeout_nxt;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign wd_expire   = 1'b0;
   assign timeout_cur = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   // Next state plus the output values of the state being entered.
   always_comb begin
      state_nxt  = state;
      bcount_nxt = bcount_q;
      hold_nxt   = hold_q;
      case (state)
         S_IDLE: begin
            if (bus.dreq && bus.dma_ena && !timeout_cur) begin
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (!bus.dma_ena || wd_expire) begin
               state_nxt = S_IDLE;
            end else if (!bus.bgrant_n) begin
               state_nxt = S_WAITBUS;
            end
         end
         S_WAITBUS: begin
            if (!bus.dma_ena || wd_expire) begin
               state_nxt = S_IDLE;
            end else if (bus.bgrant_n) begin
               state_nxt = S_REQ;
            end else if (bus.as_in_n && bus.bgack_in_n) begin
               state_nxt = S_OWN;
            end
         end
         S_OWN: begin
            state_nxt = S_RUN;
         end
         S_RUN: begin
            if (bus.cycle_done) begin
               if ((bcount_q == '1) || !bus.dreq || bus.flush || !bus.dma_ena) begin
                  state_nxt  = S_REL;
                  bcount_nxt = '0;
                  hold_nxt   = HOLD_W'(3);
               end else begin
                  state_nxt  = S_OWN;
                  bcount_nxt = bcount_q + CNT_W'(1);
               end
            end
         end
         S_REL: begin
            state_nxt = S_HOLDOFF;
         end
         S_HOLDOFF: begin
            if (hold_q == '0) begin
               state_nxt = S_IDLE;
            end else begin
               hold_nxt = hold_q - HOLD_W'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      breq_nxt  = (state_nxt == S_REQ) || (state_nxt == S_WAITBUS);
      bgack_nxt = (state_nxt == S_OWN) || (state_nxt == S_RUN);
      start_nxt = (state_nxt == S_OWN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         bcount_q <= '0;
         hold_q   <= '0;
         breq_q   <= 1'b0;
         bgack_q  <= 1'b0;
         start_q  <= 1'b0;
         owned_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         bcount_q <= bcount_nxt;
         hold_q   <= hold_nxt;
         breq_q   <= breq_nxt;
         bgack_q  <= bgack_nxt;
         start_q  <= start_nxt;
         owned_q  <= bgack_nxt;
      end
   end

   assign bus.breq   = breq_q;
   assign bus.bgack  = bgack_q;
   assign bus.start  = start_q;
   assign bus.owned  = owned_q;
   assign bus.bcount = bcount_q;
endmodule

// File: doc/cpu_bus_arbiter.md
CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

Interface
REQ-001 CLK45  input  1  Sole clock; all state changes on the rising edge.
REQ-002 nRESET  input  1  Asynchronous, active-low reset.
REQ-003 DMAENA  input  1  DMA enabled; low forces release or abort.
REQ-004 DREQ  input  1  Datapath (FIFO) needs a CPU-bus transfer.
REQ-005 FLUSH  input  1  Flush request; ends the current tenure after the in-flight cycle.
REQ-006 BGRANT_  input  1  68030 bus grant, active low.
REQ-007 BGACK_IN_  input  1  Sensed bus-grant-acknowledge, active low.
REQ-008 AS_IN_  input  1  Sensed address strobe, active low.
REQ-009 CYCLEDONE  input  1  One-cycle pulse from the cycle sequencer when a bus cycle completes.
REQ-010 BREQ  output  1  Registered bus request, active high (the top level inverts it).
REQ-011 BGACK  output  1  Registered bus-grant-acknowledge, active high (the top level inverts it).
REQ-012 START  output  1  Registered one-cycle pulse that starts one bus cycle.
REQ-013 OWNED  output  1  High while the block holds bus mastership.
REQ-014 BCOUNT  output  2  Number of cycles completed in the current tenure.
REQ-015 TIMEOUT  output  1  Sticky grant-watchdog flag.

Function
REQ-016 The state machine SHALL have seven states: IDLE, REQ, WAITBUS, OWN, RUN, REL, HOLDOFF.
REQ-017 All outputs SHALL be registered; each output SHALL reflect the state entered on the same edge.
REQ-018 IDLE -> REQ when DREQ=1, DMAENA=1 and TIMEOUT=0; BREQ=1 in REQ and in WAITBUS.
REQ-019 REQ -> WAITBUS when BGRANT_=0.
REQ-020 WAITBUS -> OWN when AS_IN_=1 and BGACK_IN_=1 (the previous master is off the bus).
REQ-021 In OWN, BREQ SHALL be 0, BGACK=1 and OWNED=1, and START SHALL be 1 for exactly that one cycle.
REQ-022 OWN -> RUN unconditionally; BGACK and OWNED SHALL stay 1 in RUN.
REQ-023 In RUN, on CYCLEDONE=1 BCOUNT SHALL increment (2-bit, modulo 4).
REQ-024 On that same CYCLEDONE, RUN -> REL if the pre-increment BCOUNT was 3, or DREQ=0, or FLUSH=1, or DMAENA=0; otherwise RUN -> OWN (back-to-back START).
REQ-025 Burst length SHALL be at most 4 cycles per tenure.
REQ-026 REL SHALL last one cycle with BGACK=0 and OWNED=0.
REQ-027 On entry to REL, BCOUNT SHALL clear to 0 and a 2-bit holdoff counter SHALL load 3.
REQ-028 HOLDOFF SHALL decrement the holdoff counter each cycle and go to IDLE on the cycle after it reads 0; HOLDOFF therefore lasts 4 cycles and BREQ is not reasserted within 5 cycles of BGACK falling.
REQ-029 DMAENA=0 in REQ or WAITBUS SHALL return the machine to IDLE on the next edge, with BREQ=0.
REQ-030 DMAENA=0 in OWN or RUN SHALL NOT abort the in-flight cycle; the release follows CYCLEDONE per REQ-024.
REQ-031 BGRANT_ deasserting in WAITBUS before ownership is taken SHALL return the machine to REQ.
REQ-032 CYCLEDONE outside RUN SHALL be ignored.

Reset
REQ-033 nRESET=0 SHALL force IDLE, BREQ=0, BGACK=0, START=0, OWNED=0, BCOUNT=0, TIMEOUT=0, holdoff=0, watchdog=0, independent of CLK45.
REQ-034 Reset asserted mid-tenure SHALL drop BGACK immediately (asynchronously), with no REL/HOLDOFF sequence.

Configuration
REQ-035 Macro CPU_ARB_WATCHDOG_EN defined: an 8-bit watchdog SHALL count cycles spent in REQ or WAITBUS and clear in every other state.
REQ-036 With CPU_ARB_WATCHDOG_EN defined, when the watchdog reaches 255 the machine SHALL go to IDLE, drop BREQ and set TIMEOUT=1; TIMEOUT SHALL hold until DMAENA=0.
REQ-037 Macro undefined: no watchdog logic SHALL be built, TIMEOUT SHALL be constant 0, and REQ/WAITBUS SHALL wait indefinitely.

Verification
REQ-038 Basic tenure: DREQ=1, DMAENA=1, BGRANT_ low 3 cycles after BREQ, bus idle, DREQ held -> 4 START pulses, BCOUNT 1..3 then 0, BGACK falls after the 4th CYCLEDONE, BREQ stays low for 5 cycles after that.
REQ-039 Early stop: DREQ drops after the 2nd CYCLEDONE -> exactly 2 START pulses, REL follows immediately.
REQ-040 Bus busy: BGRANT_=0 while AS_IN_=0 for 6 cycles -> BGACK stays 0 until the cycle after AS_IN_=1 and BGACK_IN_=1.
REQ-041 Abort: DMAENA falls in WAITBUS -> BREQ=0 next cycle, no START.
REQ-042 Watchdog (macro defined): BGRANT_ held high -> TIMEOUT=1 and BREQ=0 after 255 cycles in REQ; macro undefined -> BREQ still 1 after 1000 cycles.
REQ-043 Reset during RUN -> all outputs 0 asynchronously; normal tenure resumes after release with DREQ=1.
